// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the core (port 0)
// and the host/debug loader (port 1), with a per-transaction watchdog abort.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_rden_i,
  input  logic                    m0_wren_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_hit_o,
  output logic                    m0_err_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_rden_i,
  input  logic                    m1_wren_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_hit_o,
  output logic                    m1_err_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic [ADDR_WIDTH-1:0]   d_m_addr_o,
  output logic                    d_m_rden_o,
  output logic                    d_m_wren_o,
  output logic [DATA_WIDTH/8-1:0] d_m_wmask_o,
  output logic [DATA_WIDTH-1:0]   d_m_wdata_o,
  input  logic                    d_m_hit_i,
  input  logic [DATA_WIDTH-1:0]   d_m_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                rden_q, rden_d;
  logic                wren_q, wren_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic req0, req1, grant0, grant1, expire;

  assign req0   = m0_rden_i | m0_wren_i;
  assign req1   = m1_rden_i | m1_wren_i;
  // On a tie the port that did not own the previous transaction wins.
  assign grant0 = req0 & (~req1 | last_q);
  assign grant1 = req1 & ~grant0;
  assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign m0_rdata_o  = d_m_rdata_i;
  assign m1_rdata_o  = d_m_rdata_i;
  assign d_m_addr_o  = addr_q;
  assign d_m_rden_o  = rden_q;
  assign d_m_wren_o  = wren_q;
  assign d_m_wmask_o = wmask_q;
  assign d_m_wdata_o = wdata_q;
  assign busy_o      = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rden_d   = rden_q;
    wren_d   = wren_q;
    wmask_d  = wmask_q;
    wdata_d  = wdata_q;
    m0_hit_o = 1'b0;
    m1_hit_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A simultaneous read+write request is issued as a write.
        if (grant0) begin
          state_d = ST_BUSY0;
          cnt_d   = '0;
          addr_d  = m0_addr_i;
          rden_d  = m0_rden_i & ~m0_wren_i;
          wren_d  = m0_wren_i;
          wmask_d = m0_wmask_i;
          wdata_d = m0_wdata_i;
        end else if (grant1) begin
          state_d = ST_BUSY1;
          cnt_d   = '0;
          addr_d  = m1_addr_i;
          rden_d  = m1_rden_i & ~m1_wren_i;
          wren_d  = m1_wren_i;
          wmask_d = m1_wmask_i;
          wdata_d = m1_wdata_i;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        // A hit arriving on the expiry cycle still completes normally.
        if (d_m_hit_i || expire) begin
          state_d = ST_IDLE;
          last_d  = (state_q == ST_BUSY1);
          cnt_d   = '0;
          addr_d  = '0;
          rden_d  = 1'b0;
          wren_d  = 1'b0;
          wmask_d = '0;
          wdata_d = '0;
          if (state_q == ST_BUSY0) begin
            m0_hit_o = d_m_hit_i;
            m0_err_o = ~d_m_hit_i;
          end else begin
            m1_hit_o = d_m_hit_i;
            m1_err_o = ~d_m_hit_i;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= '0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all checked
// every cycle against a transaction-level model of ownership, age and the held command.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
  localparam int          TO = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic          m0_rden_i, m0_wren_i, m1_rden_i, m1_wren_i;
  logic [MW-1:0] m0_wmask_i, m1_wmask_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_hit_o, m0_err_o, m1_hit_o, m1_err_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic [AW-1:0] d_m_addr_o;
  logic          d_m_rden_o, d_m_wren_o;
  logic [MW-1:0] d_m_wmask_o;
  logic [DW-1:0] d_m_wdata_o;
  logic          d_m_hit_i;
  logic [DW-1:0] d_m_rdata_i;
  logic          busy_o;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_rden_i(m0_rden_i), .m0_wren_i(m0_wren_i),
    .m0_wmask_i(m0_wmask_i), .m0_wdata_i(m0_wdata_i),
    .m0_hit_o(m0_hit_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_addr_i(m1_addr_i), .m1_rden_i(m1_rden_i), .m1_wren_i(m1_wren_i),
    .m1_wmask_i(m1_wmask_i), .m1_wdata_i(m1_wdata_i),
    .m1_hit_o(m1_hit_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .d_m_addr_o(d_m_addr_o), .d_m_rden_o(d_m_rden_o), .d_m_wren_o(d_m_wren_o),
    .d_m_wmask_o(d_m_wmask_o), .d_m_wdata_o(d_m_wdata_o),
    .d_m_hit_i(d_m_hit_i), .d_m_rdata_i(d_m_rdata_i), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: current owner (-1 = none), which BUSY cycle we are in (1-based), last owner.
  int            m_owner, m_age, m_last;
  logic [AW-1:0] m_addr;
  logic          m_rden, m_wren;
  logic [MW-1:0] m_wmask;
  logic [DW-1:0] m_wdata;
  bit            done0, done1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_addr = '0; m_rden = 1'b0; m_wren = 1'b0; m_wmask = '0; m_wdata = '0;
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_last = 1;
    model_clear();
  endtask

  task automatic model_edge();
    bit r0, r1;
    int g;
    done0 = 1'b0; done1 = 1'b0;
    r0 = m0_rden_i | m0_wren_i;
    r1 = m1_rden_i | m1_wren_i;
    if (rst_i) begin
      model_reset();
    end else if (m_owner < 0) begin
      g = -1;
      if (r0 && r1) g = (m_last == 0) ? 1 : 0;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
      if (g == 0) begin
        m_addr = m0_addr_i; m_rden = m0_rden_i & ~m0_wren_i; m_wren = m0_wren_i;
        m_wmask = m0_wmask_i; m_wdata = m0_wdata_i;
      end else if (g == 1) begin
        m_addr = m1_addr_i; m_rden = m1_rden_i & ~m1_wren_i; m_wren = m1_wren_i;
        m_wmask = m1_wmask_i; m_wdata = m1_wdata_i;
      end
      if (g >= 0) begin
        m_owner = g;
        m_age   = 1;
      end
    end else if (d_m_hit_i || m_age == TO) begin
      if (m_owner == 0) done0 = 1'b1;
      else              done1 = 1'b1;
      m_last  = m_owner;
      m_owner = -1;
      m_age   = 0;
      model_clear();
    end else begin
      m_age++;
    end
  endtask

  task automatic settle_check();
    #1;
    chk("busy",   64'(busy_o),      64'(m_owner >= 0));
    chk("addr",   64'(d_m_addr_o),  64'(m_addr));
    chk("rden",   64'(d_m_rden_o),  64'(m_rden));
    chk("wren",   64'(d_m_wren_o),  64'(m_wren));
    chk("wmask",  64'(d_m_wmask_o), 64'(m_wmask));
    chk("wdata",  64'(d_m_wdata_o), 64'(m_wdata));
    chk("hit0",   64'(m0_hit_o), 64'(m_owner == 0 && d_m_hit_i));
    chk("hit1",   64'(m1_hit_o), 64'(m_owner == 1 && d_m_hit_i));
    chk("err0",   64'(m0_err_o), 64'(m_owner == 0 && !d_m_hit_i && m_age == TO));
    chk("err1",   64'(m1_err_o), 64'(m_owner == 1 && !d_m_hit_i && m_age == TO));
    chk("rdata0", 64'(m0_rdata_o), 64'(d_m_rdata_i));
    chk("rdata1", 64'(m1_rdata_o), 64'(d_m_rdata_i));
  endtask

  task automatic edge_step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  logic [31:0] exp_wd [4];
  logic [3:0]  exp_wm [4];
  bit          pend0, pend1;
  logic [1:0]  sel;

  initial begin
    rst_i = 1'b1;
    m0_addr_i = '0; m0_rden_i = 1'b0; m0_wren_i = 1'b0; m0_wmask_i = '0; m0_wdata_i = '0;
    m1_addr_i = '0; m1_rden_i = 1'b0; m1_wren_i = 1'b0; m1_wmask_i = '0; m1_wdata_i = '0;
    d_m_hit_i = 1'b0; d_m_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    model_reset();

    // Reset state
    settle_check();
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_addr", 64'(d_m_addr_o), 64'(0));
    edge_step();
    rst_i = 1'b0;

    // Single read with a one-cycle memory
    m0_rden_i = 1'b1; m0_addr_i = 32'h0000_0104;
    settle_check();
    edge_step();
    d_m_hit_i = 1'b1; d_m_rdata_i = 32'hDEADBEEF;
    settle_check();
    chk("t1_addr",  64'(d_m_addr_o), 64'(32'h104));
    chk("t1_rden",  64'(d_m_rden_o), 64'(1));
    chk("t1_hit0",  64'(m0_hit_o),   64'(1));
    chk("t1_rdata", 64'(m0_rdata_o), 64'(32'hDEADBEEF));
    chk("t1_hit1",  64'(m1_hit_o),   64'(0));
    edge_step();
    m0_rden_i = 1'b0; d_m_hit_i = 1'b0;
    settle_check();
    edge_step();

    // Contention: reset so the first tie goes to port 0, then grants must alternate
    rst_i = 1'b1;
    settle_check();
    edge_step();
    rst_i = 1'b0;
    m0_wren_i = 1'b1; m0_addr_i = 32'h200; m0_wdata_i = 32'h11223344; m0_wmask_i = 4'hF;
    m1_wren_i = 1'b1; m1_addr_i = 32'h300; m1_wdata_i = 32'h000000AA; m1_wmask_i = 4'h1;
    d_m_hit_i = 1'b1;
    exp_wd = '{32'h11223344, 32'h000000AA, 32'h11223344, 32'h000000AA};
    exp_wm = '{4'hF, 4'h1, 4'hF, 4'h1};
    for (int i = 0; i < 8; i++) begin
      settle_check();
      if (i % 2 == 1) begin
        chk("t2_wdata", 64'(d_m_wdata_o), 64'(exp_wd[i/2]));
        chk("t2_wmask", 64'(d_m_wmask_o), 64'(exp_wm[i/2]));
      end
      edge_step();
    end
    m0_wren_i = 1'b0; m1_wren_i = 1'b0; d_m_hit_i = 1'b0;
    settle_check();
    edge_step();

    // Input change while BUSY, hit delayed to the third BUSY cycle
    m0_rden_i = 1'b1; m0_addr_i = 32'h10;
    settle_check();
    edge_step();
    m0_addr_i = 32'h20;
    for (int i = 1; i <= 3; i++) begin
      d_m_hit_i = (i == 3);
      settle_check();
      chk("t3_addr", 64'(d_m_addr_o), 64'(32'h10));
      chk("t3_hit0", 64'(m0_hit_o), 64'(i == 3));
      edge_step();
    end
    m0_rden_i = 1'b0; d_m_hit_i = 1'b0;
    settle_check();
    edge_step();

    // Timeout on port 1 with port 0 waiting
    m1_rden_i = 1'b1; m1_addr_i = 32'h400;
    settle_check();
    edge_step();
    m0_rden_i = 1'b1; m0_addr_i = 32'h500;
    for (int i = 1; i <= TO; i++) begin
      settle_check();
      chk("t4_err1", 64'(m1_err_o), 64'(i == TO));
      chk("t4_busy", 64'(busy_o), 64'(1));
      edge_step();
    end
    m1_rden_i = 1'b0;
    settle_check();
    chk("t4_idle", 64'(busy_o), 64'(0));
    edge_step();
    d_m_hit_i = 1'b1;
    settle_check();
    chk("t4_grant0", 64'(d_m_addr_o), 64'(32'h500));
    edge_step();
    m0_rden_i = 1'b0; d_m_hit_i = 1'b0;
    settle_check();
    edge_step();

    // Hit on the expiry cycle wins over the abort
    m0_rden_i = 1'b1; m0_addr_i = 32'h600;
    settle_check();
    edge_step();
    for (int i = 1; i <= TO; i++) begin
      d_m_hit_i = (i == TO);
      settle_check();
      chk("t5_hit0", 64'(m0_hit_o), 64'(i == TO));
      chk("t5_err0", 64'(m0_err_o), 64'(0));
      edge_step();
    end
    m0_rden_i = 1'b0; d_m_hit_i = 1'b0;
    settle_check();
    edge_step();

    // Reset during BUSY0, then a tie goes to port 0
    m0_rden_i = 1'b1; m0_addr_i = 32'h700;
    settle_check();
    edge_step();
    rst_i = 1'b1;
    settle_check();
    edge_step();
    rst_i = 1'b0;
    m1_rden_i = 1'b1; m1_addr_i = 32'h800;
    settle_check();
    chk("t6_addr", 64'(d_m_addr_o), 64'(0));
    chk("t6_rden", 64'(d_m_rden_o), 64'(0));
    chk("t6_busy", 64'(busy_o), 64'(0));
    chk("t6_hit0", 64'(m0_hit_o), 64'(0));
    chk("t6_err0", 64'(m0_err_o), 64'(0));
    edge_step();
    d_m_hit_i = 1'b1;
    settle_check();
    chk("t6_tie0", 64'(d_m_addr_o), 64'(32'h700));
    edge_step();
    m0_rden_i = 1'b0; m1_rden_i = 1'b0; d_m_hit_i = 1'b0;
    settle_check();
    edge_step();

    // Random traffic: requesters hold until hit/err, memory latency random
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1;
        sel = 2'($urandom_range(1, 3));
        m0_rden_i = sel[0]; m0_wren_i = sel[1];
        m0_addr_i = $urandom; m0_wdata_i = $urandom; m0_wmask_i = 4'($urandom);
      end else if (!pend0) begin
        m0_rden_i = 1'b0; m0_wren_i = 1'b0; m0_addr_i = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1;
        sel = 2'($urandom_range(1, 3));
        m1_rden_i = sel[0]; m1_wren_i = sel[1];
        m1_addr_i = $urandom; m1_wdata_i = $urandom; m1_wmask_i = 4'($urandom);
      end else if (!pend1) begin
        m1_rden_i = 1'b0; m1_wren_i = 1'b0; m1_addr_i = $urandom;
      end
      d_m_hit_i   = ($urandom_range(0, 2) == 0);
      d_m_rdata_i = $urandom;
      settle_check();
      edge_step();
      if (done0 || rst_i) begin
        pend0 = 1'b0; m0_rden_i = 1'b0; m0_wren_i = 1'b0;
      end
      if (done1 || rst_i) begin
        pend1 = 1'b0; m1_rden_i = 1'b0; m1_wren_i = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
